// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcode classes, load subtypes
// and the default peripheral/DMEM address split.
package wb_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;

    localparam logic [2:0] LOAD_PREFIX   = 3'b100;
    localparam logic [2:0] STORE_PREFIX  = 3'b101;
    localparam logic [2:0] BRANCH_PREFIX = 3'b110;
    localparam logic [3:0] MUL_PREFIX    = 4'b1111;

    localparam int PERIPH_BASE_DEFAULT = 512;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_sub_e;

    typedef enum logic [2:0] {
        CLASS_ALU,
        CLASS_LOAD,
        CLASS_STORE,
        CLASS_BRANCH,
        CLASS_MUL
    } op_class_e;

    function automatic op_class_e classify(input logic [5:0] op);
        if (op[5:2] == MUL_PREFIX)
            return CLASS_MUL;
        else if (op[5:3] == LOAD_PREFIX)
            return CLASS_LOAD;
        else if (op[5:3] == STORE_PREFIX)
            return CLASS_STORE;
        else if (op[5:3] == BRANCH_PREFIX)
            return CLASS_BRANCH;
        else
            return CLASS_ALU;
    endfunction

    function automatic logic writes_rd(input op_class_e cls);
        return (cls == CLASS_ALU) || (cls == CLASS_LOAD) || (cls == CLASS_MUL);
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian byte/halfword extraction with sign or zero extension for loads,
// plus detection of halfword/word accesses that straddle their natural alignment.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  subtype,
    output logic [31:0] value,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    // Unknown subtype codes fall into the word case on purpose.
    always_comb begin
        value      = word;
        misaligned = 1'b0;
        case (subtype)
            LD_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU: value = {24'b0, byte_sel};
            LD_LH: begin
                value      = {{16{half_sel[15]}}, half_sel};
                misaligned = offset[0];
            end
            LD_LHU: begin
                value      = {16'b0, half_sel};
                misaligned = offset[0];
            end
            default: begin
                value      = word;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/pipeline_wb.sv
// Writeback stage: picks and aligns the result, drives the registered regfile
// write port, keeps a one-deep forwarding copy and counts retired instructions.
module pipeline_wb
    import wb_pkg::*;
#(
    parameter int COUNT_W     = 32,
    parameter int PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode_i,
    input  logic [31:0]        alu_out_i,
    input  logic [4:0]         rd_i,
    input  logic               stall_i,
    input  logic               valid_stall_i,
    input  logic [31:0]        peripheral_read_i,
    input  logic [31:0]        dmem_read_i,
    input  logic [31:0]        mul_read_i,
    output logic               rf_we_o,
    output logic [4:0]         rf_waddr_o,
    output logic [31:0]        rf_wdata_o,
    output logic               fwd_valid_o,
    output logic [4:0]         fwd_rd_o,
    output logic [31:0]        fwd_data_o,
    output logic               misalign_o,
    output logic [COUNT_W-1:0] retired_o
);

    localparam logic [31:0]        PERIPH_BASE_W = 32'(PERIPH_BASE);
    localparam logic [COUNT_W-1:0] COUNT_ONE     = COUNT_W'(1);

    op_class_e   op_class;
    logic        consume;
    logic [31:0] src_word;
    logic [31:0] load_value;
    logic        load_misaligned;
    logic        misaligned;
    logic        do_write;
    logic [31:0] result;

    load_align u_load_align (
        .word       (src_word),
        .offset     (alu_out_i[1:0]),
        .subtype    (opcode_i[2:0]),
        .value      (load_value),
        .misaligned (load_misaligned)
    );

    // A held instruction under valid_stall_i is only taken once the stall drops.
    always_comb begin
        op_class   = classify(opcode_i);
        consume    = !valid_stall_i && !stall_i && (opcode_i != OP_NOP);
        src_word   = (alu_out_i >= PERIPH_BASE_W) ? peripheral_read_i : dmem_read_i;
        misaligned = (op_class == CLASS_LOAD) && load_misaligned;
        do_write   = writes_rd(op_class) && (rd_i != 5'd0) && !misaligned;
    end

    always_comb begin
        case (op_class)
            CLASS_MUL:  result = mul_read_i;
            CLASS_LOAD: result = load_value;
            default:    result = alu_out_i;
        endcase
    end

    // Misaligned loads, stores and rd==0 writes still retire even though nothing is written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we_o     <= 1'b0;
            rf_waddr_o  <= 5'd0;
            rf_wdata_o  <= 32'd0;
            fwd_valid_o <= 1'b0;
            fwd_rd_o    <= 5'd0;
            fwd_data_o  <= 32'd0;
            misalign_o  <= 1'b0;
            retired_o   <= '0;
        end else begin
            fwd_valid_o <= rf_we_o;
            fwd_rd_o    <= rf_waddr_o;
            fwd_data_o  <= rf_wdata_o;
            if (consume) begin
                rf_we_o    <= do_write;
                rf_waddr_o <= rd_i;
                rf_wdata_o <= result;
                misalign_o <= misaligned;
                retired_o  <= retired_o + COUNT_ONE;
            end else begin
                rf_we_o    <= 1'b0;
                misalign_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_wb.sv
// Self-checking bench for pipeline_wb: expected write-port results are queued
// as each instruction is driven and popped one edge later.
module tb_pipeline_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode_i;
    logic [31:0] alu_out_i;
    logic [4:0]  rd_i;
    logic        stall_i;
    logic        valid_stall_i;
    logic [31:0] peripheral_read_i;
    logic [31:0] dmem_read_i;
    logic [31:0] mul_read_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
    logic        misalign_o;
    logic [31:0] retired_o;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_retired = 32'd0;

    always #5 clk = ~clk;

    pipeline_wb #(.COUNT_W(32), .PERIPH_BASE(512)) dut (
        .clk               (clk),
        .reset             (reset),
        .opcode_i          (opcode_i),
        .alu_out_i         (alu_out_i),
        .rd_i              (rd_i),
        .stall_i           (stall_i),
        .valid_stall_i     (valid_stall_i),
        .peripheral_read_i (peripheral_read_i),
        .dmem_read_i       (dmem_read_i),
        .mul_read_i        (mul_read_i),
        .rf_we_o           (rf_we_o),
        .rf_waddr_o        (rf_waddr_o),
        .rf_wdata_o        (rf_wdata_o),
        .fwd_valid_o       (fwd_valid_o),
        .fwd_rd_o          (fwd_rd_o),
        .fwd_data_o        (fwd_data_o),
        .misalign_o        (misalign_o),
        .retired_o         (retired_o)
    );

    task automatic drive(input logic [5:0] op, input logic [31:0] alu, input logic [4:0] rd,
                         input logic st, input logic vst, input logic [31:0] per,
                         input logic [31:0] dmem, input logic [31:0] mul);
        opcode_i          = op;
        alu_out_i         = alu;
        rd_i              = rd;
        stall_i           = st;
        valid_stall_i     = vst;
        peripheral_read_i = per;
        dmem_read_i       = dmem;
        mul_read_i        = mul;
    endtask

    task automatic expect_wb(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                             input logic mis);
        exp_t e;
        e.we = we; e.waddr = waddr; e.wdata = wdata; e.mis = mis;
        sb.push_back(e);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(6'b000001, 32'h99, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        advance();
        advance();
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_rd_o, fwd_data_o, misalign_o} !== 76'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got we=%0b waddr=%0d wdata=%h fv=%0b frd=%0d fdata=%h mis=%0b want all 0",
                     rf_we_o, rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_rd_o, fwd_data_o, misalign_o);
        end
        total++;
        if (retired_o !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_retired: got %0d want 0", retired_o);
        end
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b1;
    endtask

    task automatic test_alu_forward();
        exp_t e;
        drive(6'b000001, 32'h1234, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        expect_wb(1'b1, 5'd5, 32'h1234, 1'b0);
        exp_retired++;
        advance();
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        e = sb.pop_front();
        total++;
        if (rf_we_o !== e.we || rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata) begin
            bad++;
            $display("[TB] FAIL alu_write: got we=%0b waddr=%0d wdata=%h want we=%0b waddr=%0d wdata=%h",
                     rf_we_o, rf_waddr_o, rf_wdata_o, e.we, e.waddr, e.wdata);
        end
        total++;
        if (retired_o !== exp_retired) begin
            bad++;
            $display("[TB] FAIL alu_retired: got %0d want %0d", retired_o, exp_retired);
        end
        advance();
        total++;
        if (fwd_valid_o !== 1'b1 || fwd_rd_o !== 5'd5 || fwd_data_o !== 32'h1234) begin
            bad++;
            $display("[TB] FAIL alu_forward: got fv=%0b frd=%0d fdata=%h want fv=1 frd=5 fdata=00001234",
                     fwd_valid_o, fwd_rd_o, fwd_data_o);
        end
        total++;
        if (rf_we_o !== 1'b0 || rf_waddr_o !== 5'd5 || rf_wdata_o !== 32'h1234) begin
            bad++;
            $display("[TB] FAIL idle_hold: got we=%0b waddr=%0d wdata=%h want we=0 waddr=5 wdata=00001234",
                     rf_we_o, rf_waddr_o, rf_wdata_o);
        end
    endtask

    // Back-to-back LB then LBU on identical inputs.
    task automatic test_sign_ext();
        exp_t e;
        drive(6'b100000, 32'h11, 5'd3, 1'b0, 1'b0, 32'h0, 32'h0000_8000, 32'h0);
        expect_wb(1'b1, 5'd3, 32'hFFFF_FF80, 1'b0);
        exp_retired++;
        advance();
        drive(6'b100100, 32'h11, 5'd4, 1'b0, 1'b0, 32'h0, 32'h0000_8000, 32'h0);
        expect_wb(1'b1, 5'd4, 32'h0000_0080, 1'b0);
        exp_retired++;
        e = sb.pop_front();
        total++;
        if (rf_we_o !== e.we || rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata) begin
            bad++;
            $display("[TB] FAIL lb_sign: got we=%0b waddr=%0d wdata=%h want we=%0b waddr=%0d wdata=%h",
                     rf_we_o, rf_waddr_o, rf_wdata_o, e.we, e.waddr, e.wdata);
        end
        advance();
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        e = sb.pop_front();
        total++;
        if (rf_we_o !== e.we || rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata) begin
            bad++;
            $display("[TB] FAIL lbu_zero: got we=%0b waddr=%0d wdata=%h want we=%0b waddr=%0d wdata=%h",
                     rf_we_o, rf_waddr_o, rf_wdata_o, e.we, e.waddr, e.wdata);
        end
        total++;
        if (retired_o !== exp_retired) begin
            bad++;
            $display("[TB] FAIL ext_retired: got %0d want %0d", retired_o, exp_retired);
        end
    endtask

    // LHU from peripheral space, then LW either side of the 0x200 split.
    task automatic test_periph_boundary();
        exp_t e;
        logic [5:0]  ops[3]  = '{6'b100101, 6'b100010, 6'b100010};
        logic [31:0] addr[3] = '{32'h202, 32'h1FC, 32'h200};
        logic [31:0] per[3]  = '{32'hBEEF_0000, 32'h5A5A_5A5A, 32'h5A5A_5A5A};
        logic [31:0] dm[3]   = '{32'h1234_5678, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        logic [31:0] want[3] = '{32'h0000_BEEF, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], addr[i], 5'(10 + i), 1'b0, 1'b0, per[i], dm[i], 32'h0);
            expect_wb(1'b1, 5'(10 + i), want[i], 1'b0);
            exp_retired++;
            advance();
            e = sb.pop_front();
            total++;
            if (rf_we_o !== e.we || rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata) begin
                bad++;
                $display("[TB] FAIL periph_src[%0d]: got we=%0b waddr=%0d wdata=%h want we=%0b waddr=%0d wdata=%h",
                         i, rf_we_o, rf_waddr_o, rf_wdata_o, e.we, e.waddr, e.wdata);
            end
        end
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    // Misaligned LW, misaligned LH, aligned signed LH: pulse must last exactly one cycle.
    task automatic test_misalign();
        exp_t e;
        logic [5:0]  ops[4]  = '{6'b100010, 6'b000000, 6'b100001, 6'b100001};
        logic [31:0] addr[4] = '{32'h6, 32'h0, 32'h3, 32'h2};
        logic        wwe[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic        wmis[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], addr[i], 5'd9, 1'b0, 1'b0, 32'h0, 32'h8001_0000, 32'h0);
            expect_wb(wwe[i], 5'd9, 32'hFFFF_8001, wmis[i]);
            if (ops[i] != 6'b000000) exp_retired++;
            advance();
            e = sb.pop_front();
            total++;
            if (rf_we_o !== e.we || misalign_o !== e.mis) begin
                bad++;
                $display("[TB] FAIL misalign[%0d]: got we=%0b mis=%0b want we=%0b mis=%0b",
                         i, rf_we_o, misalign_o, e.we, e.mis);
            end
            total++;
            if (e.we && rf_wdata_o !== e.wdata) begin
                bad++;
                $display("[TB] FAIL lh_sign[%0d]: got %h want %h", i, rf_wdata_o, e.wdata);
            end
            total++;
            if (retired_o !== exp_retired) begin
                bad++;
                $display("[TB] FAIL misalign_retired[%0d]: got %0d want %0d", i, retired_o, exp_retired);
            end
        end
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_mul_stall();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive(6'b111100, 32'h0, 5'd7, 1'b0, (i < 3), 32'h0, 32'h0, 32'd42);
            expect_wb((i == 3), 5'd7, 32'd42, 1'b0);
            if (i == 3) exp_retired++;
            advance();
            e = sb.pop_front();
            total++;
            if (rf_we_o !== e.we || (e.we && (rf_waddr_o !== e.waddr || rf_wdata_o !== e.wdata))) begin
                bad++;
                $display("[TB] FAIL mul_stall[%0d]: got we=%0b waddr=%0d wdata=%0d want we=%0b waddr=%0d wdata=%0d",
                         i, rf_we_o, rf_waddr_o, rf_wdata_o, e.we, e.waddr, e.wdata);
            end
            total++;
            if (retired_o !== exp_retired) begin
                bad++;
                $display("[TB] FAIL mul_retired[%0d]: got %0d want %0d", i, retired_o, exp_retired);
            end
        end
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        advance();
        total++;
        if (rf_we_o !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mul_once: got we=%0b want 0", rf_we_o);
        end
    endtask

    // Store, branch, bubble, double stall, rd==0 ALU: none write; only the consumed ones count.
    task automatic test_no_write();
        exp_t e;
        logic [5:0] ops[5] = '{6'b101000, 6'b110011, 6'b000001, 6'b000001, 6'b000001};
        logic [4:0] rds[5] = '{5'd4, 5'd6, 5'd8, 5'd8, 5'd0};
        logic       st[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic       vst[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       cnt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], 32'h55, rds[i], st[i], vst[i], 32'h0, 32'h0, 32'h0);
            expect_wb(1'b0, rds[i], 32'h55, 1'b0);
            if (cnt[i]) exp_retired++;
            advance();
            e = sb.pop_front();
            total++;
            if (rf_we_o !== e.we) begin
                bad++;
                $display("[TB] FAIL no_write[%0d]: got we=%0b want %0b", i, rf_we_o, e.we);
            end
            total++;
            if (retired_o !== exp_retired) begin
                bad++;
                $display("[TB] FAIL no_write_retired[%0d]: got %0d want %0d", i, retired_o, exp_retired);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(6'b000001, 32'h77, 5'd6, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        advance();
        exp_retired = 32'd0;
        total++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_rd_o, fwd_data_o, misalign_o} !== 76'd0 ||
            retired_o !== exp_retired) begin
            bad++;
            $display("[TB] FAIL midstream_reset: got we=%0b waddr=%0d wdata=%h fv=%0b frd=%0d fdata=%h mis=%0b ret=%0d want all 0",
                     rf_we_o, rf_waddr_o, rf_wdata_o, fwd_valid_o, fwd_rd_o, fwd_data_o, misalign_o, retired_o);
        end
        reset = 1'b1;
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        advance();
        total++;
        if (rf_we_o !== 1'b0 || fwd_valid_o !== 1'b0 || retired_o !== 32'd0) begin
            bad++;
            $display("[TB] FAIL after_reset: got we=%0b fv=%0b ret=%0d want 0 0 0", rf_we_o, fwd_valid_o, retired_o);
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(6'b000000, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        test_reset();
        test_alu_forward();
        test_sign_ext();
        test_periph_boundary();
        test_misalign();
        test_mul_stall();
        test_no_write();
        test_reset_midstream();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/pipeline_wb.md
Name: pipeline_wb

Overview:
- Writeback stage directly downstream of the memory stage. Consumes its registered opcode, ALU result, rd and the three read buses (peripheral, DMEM, multiply).
- Selects and aligns the result, including byte/halfword extraction with sign/zero extension for loads, and drives a registered register-file write port.
- Provides a one-deep forwarding register that covers regfile read-during-write, plus a retired-instruction counter.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.
- PERIPH_BASE, 512, byte address at or above which loads return peripheral data; below it they return DMEM data.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low (asserted at 0)
- opcode_i  input  6  opcode from memory stage
- alu_out_i  input  32  ALU result / load byte address
- rd_i  input  5  destination register
- stall_i  input  1  bubble marker from memory stage (1 = no instruction)
- valid_stall_i  input  1  memory stage waiting on a multi-cycle unit; inputs not consumable
- peripheral_read_i  input  32  peripheral read word
- dmem_read_i  input  32  DMEM read word
- mul_read_i  input  32  multiply result
- rf_we_o  output  1  register-file write enable
- rf_waddr_o  output  5  write address
- rf_wdata_o  output  32  write data
- fwd_valid_o  output  1  previous-cycle write still forwardable
- fwd_rd_o  output  5  forwarded register
- fwd_data_o  output  32  forwarded data
- misalign_o  output  1  one-cycle pulse: misaligned load dropped
- retired_o  output  COUNT_W  retired-instruction count

Behaviour:
- Reset (reset==0 at a clk edge): every output is 0, including the counter.
- Consume condition C = valid_stall_i==0 && stall_i==0 && opcode_i!=OP_NOP (6'b000000).
- Opcode classes:
  - LOAD = opcode_i[5:3]==3'b100
  - STORE = 3'b101
  - BRANCH = 3'b110
  - MUL = opcode_i[5:2]==4'b1111
  - anything else is ALU.
- Writes: LOAD, MUL and ALU write rd; STORE and BRANCH never write.
- Load subtype is opcode_i[2:0]: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other code is treated as LW.
- Source word: peripheral_read_i when alu_out_i >= PERIPH_BASE, else dmem_read_i. Byte offset is alu_out_i[1:0], little-endian.
- Alignment extraction:
  - LB/LBU: byte at offset, sign/zero-extended.
  - LH/LHU: halfword at offset[1], extended.
  - LW: full word.
- Misalignment: LH/LHU with offset[0]==1, or LW with offset!=0, is misaligned. The write is suppressed, misalign_o is 1 for exactly the next cycle, and the instruction still counts as retired.
- Result select: MUL -> mul_read_i; ALU -> alu_out_i; LOAD -> aligned value.
- Latency: one cycle. At the edge where C holds, rf_we_o <= (writes class) && rd_i!=0 && !misaligned; rf_waddr_o <= rd_i; rf_wdata_o <= result.
- Edge where C is false: rf_we_o <= 0; rf_waddr_o and rf_wdata_o hold. A held instruction under valid_stall_i is consumed once, on the first edge with valid_stall_i==0.
- Forwarding: every edge, fwd_valid_o <= rf_we_o, fwd_rd_o <= rf_waddr_o, fwd_data_o <= rf_wdata_o. Forward data is therefore exactly one cycle behind the write port.
- Counter:
  - retired_o increments by 1 on each edge where C holds.
  - Stores, branches, misaligned loads and rd==0 writes all count.
  - Wraps modulo 2^COUNT_W with no saturation.
- Reset mid-stream: pending write is discarded; misalign pulse, forward entry and counter are all cleared.
- valid_stall_i and stall_i both 1: not consumed; no write, no count.

Decomposition:
- Package wb_pkg holds: OP_NOP, class prefixes (LOAD 3'b100, STORE 3'b101, BRANCH 3'b110, MUL 4'b1111), load subtype codes (LB/LH/LW/LBU/LHU), and default PERIPH_BASE.
- One combinational sub-module, load_align:
  - inputs: word, offset[1:0], subtype[2:0]
  - outputs: value[31:0], misaligned
- Select logic, pipeline registers, forwarding and counter stay in pipeline_wb.

Test Plan:
- ALU op opcode 6'b000001, rd 5, alu_out 0x1234 -> next cycle rf_we_o=1, waddr 5, wdata 0x1234. Following cycle fwd_valid_o=1, fwd_rd_o=5, fwd_data_o=0x1234. retired_o=1.
- Sign extension: LB, addr 0x11 (offset 1), dmem_read 0x0000_8000 -> wdata 0xFFFF_FF80. LBU on the same inputs -> 0x0000_0080.
- Peripheral halfword: LHU addr 0x202, peripheral_read 0xBEEF_0000 -> wdata 0x0000_BEEF (source is peripheral_read_i, not DMEM).
- Misaligned LW at addr 0x6 -> rf_we_o=0, misalign_o=1 for exactly one cycle, retired_o increments.
- MUL opcode 6'b111100, rd 7, mul_read 42, with valid_stall_i held 1 for 3 cycles then 0 -> exactly one write of 42 to r7 after the release edge; counter increments once.
- Store, bubble (stall_i=1) and rd=0 ALU each presented -> no write. Store and rd=0 ALU count; the bubble does not. Then reset=0 for one cycle -> all outputs 0.
